// File: rtl/pc_redirect_ctrl.sv
// PC redirect and hazard sequencer: applies EX-stage branch/jump redirects, holds them while fetch is busy,
// and inserts load-use bubbles. Define REDIRECT_PERF_EN to build the redirect/stall performance counters.
module pc_redirect_ctrl #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_pc_sel,
  input  logic [31:0]     ex_branch_target,
  input  logic            imem_ready,
  input  logic            id_ex_mem_read,
  input  logic [4:0]      id_ex_rd,
  input  logic [4:0]      if_id_rs1,
  input  logic [4:0]      if_id_rs2,
  output logic            pc_write,
  output logic            pc_src,
  output logic [PC_W-1:0] redirect_pc,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            target_misaligned,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     stall_cnt
);

  typedef enum logic {RUN, PEND} state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pend_pc, pend_pc_next;
  logic            lu;
  logic            redir;

  assign lu    = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                 ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign redir = ex_valid && ex_pc_sel;

  // Target bits above PC_W are dropped on purpose.
  generate
    if (PC_W < 32) begin : g_drop_hi
      logic unused_target_hi;
      assign unused_target_hi = ^ex_branch_target[31:PC_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      pend_pc <= pend_pc_next;
    end
  end

  always_comb begin
    state_next        = state;
    pend_pc_next      = pend_pc;
    pc_write          = 1'b0;
    pc_src            = 1'b0;
    redirect_pc       = ex_branch_target[PC_W-1:0];
    if_id_write       = 1'b1;
    if_id_flush       = 1'b0;
    id_ex_flush       = 1'b0;
    target_misaligned = 1'b0;
    case (state)
      RUN: begin
        if (redir) begin
          // A redirect squashes the instruction a load-use stall would hold, so lu is moot here.
          pc_src            = 1'b1;
          if_id_flush       = 1'b1;
          id_ex_flush       = 1'b1;
          target_misaligned = ex_branch_target[1];
          if (imem_ready) begin
            pc_write = 1'b1;
          end else begin
            pend_pc_next = ex_branch_target[PC_W-1:0];
            state_next   = PEND;
          end
        end else if (lu) begin
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else begin
          pc_write = imem_ready;
        end
      end
      PEND: begin
        redirect_pc = pend_pc;
        pc_src      = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (imem_ready) begin
          pc_write   = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

`ifdef REDIRECT_PERF_EN
  logic        accept;
  logic        stall;
  logic [31:0] redirect_cnt_reg;
  logic [31:0] stall_cnt_reg;

  assign accept = (state == RUN) && redir;
  assign stall  = (state == PEND) || ((state == RUN) && !redir && lu);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt_reg <= '0;
      stall_cnt_reg    <= '0;
    end else begin
      if (accept) redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
      if (stall)  stall_cnt_reg    <= stall_cnt_reg + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_reg;
  assign stall_cnt    = stall_cnt_reg;
`else
  assign redirect_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed-vector bench for pc_redirect_ctrl; counter expectations follow REDIRECT_PERF_EN.
module tb_pc_redirect_ctrl;

`ifdef REDIRECT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_pc_sel, imem_ready, id_ex_mem_read;
  logic [31:0] ex_branch_target;
  logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2;
  logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, target_misaligned;
  logic [8:0]  redirect_pc;
  logic [31:0] redirect_cnt, stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int rc = 0;
  int sc = 0;

  pc_redirect_ctrl #(.PC_W(9)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc_sel(ex_pc_sel),
    .ex_branch_target(ex_branch_target), .imem_ready(imem_ready),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .pc_write(pc_write), .pc_src(pc_src), .redirect_pc(redirect_pc),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .target_misaligned(target_misaligned), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [31:0] tgt, input logic rdy,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ex_valid = v; ex_pc_sel = sel; ex_branch_target = tgt; imem_ready = rdy;
    id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_rcnt"}, redirect_cnt, PERF ? rc : 0);
    check({tag, "_scnt"}, stall_cnt,    PERF ? sc : 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_src", pc_src, 0);
    check("rst_pc_write", pc_write, 1);
    check_cnt("rst");
    reset = 1'b0;
    step();

    // Taken redirect with fetch ready
    drive(1, 1, 32'h0000_0124, 1, 0, 5'd0, 5'd0, 5'd0);
    check("r124_pc_write", pc_write, 1);
    check("r124_pc_src", pc_src, 1);
    check("r124_redirect_pc", redirect_pc, 9'h124);
    check("r124_if_id_flush", if_id_flush, 1);
    check("r124_id_ex_flush", id_ex_flush, 1);
    check("r124_misaligned", target_misaligned, 0);
    step(); rc++;
    drive(0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0);
    check("r124_after_pc_src", pc_src, 0);
    check_cnt("r124");

    // Redirect to 0x0F0 while fetch busy for three cycles
    drive(1, 1, 32'h0000_00F0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("rF0_c0_pc_write", pc_write, 0);
    check("rF0_c0_if_id_flush", if_id_flush, 1);
    check("rF0_c0_id_ex_flush", id_ex_flush, 1);
    step(); rc++;
    for (int i = 1; i < 3; i++) begin
      drive(1, 1, 32'h0000_01FC, 0, 1, 5'd3, 5'd3, 5'd0);
      check($sformatf("rF0_c%0d_pc_write", i), pc_write, 0);
      check($sformatf("rF0_c%0d_pc_src", i), pc_src, 1);
      check($sformatf("rF0_c%0d_redirect_pc", i), redirect_pc, 9'h0F0);
      check($sformatf("rF0_c%0d_if_id_flush", i), if_id_flush, 1);
      check($sformatf("rF0_c%0d_id_ex_flush", i), id_ex_flush, 1);
      step(); sc++;
    end
    drive(0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0);
    check("rF0_c3_pc_write", pc_write, 1);
    check("rF0_c3_redirect_pc", redirect_pc, 9'h0F0);
    check("rF0_c3_pc_src", pc_src, 1);
    step(); sc++;
    check("rF0_run_pc_src", pc_src, 0);
    check("rF0_run_if_id_flush", if_id_flush, 0);
    check_cnt("rF0");

    // Load-use hazard, then same pattern with rd=0
    drive(0, 0, 32'h0, 1, 1, 5'd5, 5'd1, 5'd5);
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    check("lu_if_id_flush", if_id_flush, 0);
    step(); sc++;
    drive(0, 0, 32'h0, 1, 1, 5'd0, 5'd0, 5'd0);
    check("lu0_pc_write", pc_write, 1);
    check("lu0_if_id_write", if_id_write, 1);
    check("lu0_id_ex_flush", id_ex_flush, 0);
    step();
    check_cnt("lu");

    // Load-use and redirect together: redirect wins
    drive(1, 1, 32'h0000_0040, 1, 1, 5'd7, 5'd7, 5'd2);
    check("lur_pc_src", pc_src, 1);
    check("lur_pc_write", pc_write, 1);
    check("lur_redirect_pc", redirect_pc, 9'h040);
    check("lur_if_id_write", if_id_write, 1);
    check("lur_id_ex_flush", id_ex_flush, 1);
    step(); rc++;
    drive(0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0);
    check_cnt("lur");

    // Oversized, misaligned target
    drive(1, 1, 32'h0000_0A06, 1, 0, 5'd0, 5'd0, 5'd0);
    check("mis_redirect_pc", redirect_pc, 9'h006);
    check("mis_pulse", target_misaligned, 1);
    step(); rc++;
    drive(0, 0, 32'h0000_0A06, 1, 0, 5'd0, 5'd0, 5'd0);
    check("mis_after", target_misaligned, 0);
    check_cnt("mis");

    // Reset while a redirect to 0x080 is pending
    drive(1, 1, 32'h0000_0080, 0, 0, 5'd0, 5'd0, 5'd0);
    step(); rc++;
    drive(0, 0, 32'h0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("rp_pend_redirect_pc", redirect_pc, 9'h080);
    check("rp_pend_pc_src", pc_src, 1);
    reset = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 5'd0, 5'd0, 5'd0);
    rc = 0; sc = 0;
    check("rp_rst_pc_src", pc_src, 0);
    check_cnt("rp_rst");
    step();
    reset = 1'b0;
    step();
    check("rp_run_pc_src", pc_src, 0);
    check("rp_run_pc_write", pc_write, 1);
    check("rp_run_if_id_flush", if_id_flush, 0);
    step();
    check("rp_run2_pc_src", pc_src, 0);
    check_cnt("rp_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
